irq_ctl: RTL and testbench

Interrupt controller aggregating the per-module interrupt vector (logic analyzer, logic generator, MNO oscilloscopes, MNG generators) into one level interrupt toward the PS. It latches events into sticky pending bits and masks them. A round-robin arbiter presents one source number at a time over a valid/ready handshake. It sits at the top level between the instrument modules and the PS interrupt input, and its configuration comes from the housekeeping register bank.

---
 rtl/irq_ctl_pkg.sv | 18 +
 rtl/irq_ctl_if.sv | 14 +
 rtl/irq_ctl_arb.sv | 34 +++
 rtl/irq_ctl.sv | 114 +++++++++++
 tb/tb_irq_ctl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/irq_ctl_pkg.sv
// Shared types for the interrupt controller: source vector layout, source index and FSM states.
// Bit order: gen at the bottom, then osc, la, lg at the top.
package irq_ctl_pkg;

  typedef struct packed {
    logic       lg;
    logic       la;
    logic [1:0] osc;
    logic [1:0] gen;
  } irq_t;

  localparam int IRQ_N = $bits(irq_t);

  typedef logic [$clog2(IRQ_N)-1:0] irq_num_t;

  typedef enum logic {IDLE, OFFER} irq_ctl_st_t;

endpackage

// File: rtl/irq_ctl_if.sv
// Vector handshake between the interrupt controller (master) and its consumer (slave).
// vec_num is only meaningful while vec_vld is high.
interface irq_ctl_if #(
  parameter int N = irq_ctl_pkg::IRQ_N
);

  logic                 vec_vld;
  logic [$clog2(N)-1:0] vec_num;
  logic                 vec_rdy;

  modport master (output vec_vld, output vec_num, input vec_rdy);
  modport slave  (input vec_vld, input vec_num, output vec_rdy);

endinterface

// File: rtl/irq_ctl_arb.sv
// Combinational round-robin search: first set req bit at or after ptr, wrapping N-1 -> 0.
// Zero latency, no state.
module irq_ctl_arb #(
  parameter  int N  = irq_ctl_pkg::IRQ_N,
  localparam int NW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [NW-1:0] ptr,
  output logic          gnt_vld,
  output logic [NW-1:0] gnt_num
);

  localparam int IW = NW + 1;

  logic [IW-1:0] idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_num = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      // ptr + i stays below 2N, so one conditional subtract gives the modulo
      idx = {1'b0, ptr} + IW'(i);
      if (idx >= IW'(N)) begin
        idx = idx - IW'(N);
      end
      if (!gnt_vld && req[idx[NW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_num = idx[NW-1:0];
      end
    end
  end

endmodule

// File: rtl/irq_ctl.sv
// Interrupt controller: sticky pending, mask, round-robin vector offer, registered level irq; event to vec_vld/irq in 2 cycles.
// vec_num held until vec_rdy; optional post-handshake hold-off when IRQ_CTL_HOLDOFF_EN is defined.
module irq_ctl #(
  parameter  int IRQ_N = $bits(irq_ctl_pkg::irq_t),
  localparam int NW    = $clog2(IRQ_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IRQ_N-1:0] irq_src,
  input  logic [IRQ_N-1:0] cfg_msk,
  input  logic [IRQ_N-1:0] cfg_edg,
  input  logic             clr_vld,
  input  logic [IRQ_N-1:0] clr_msk,
  output logic [IRQ_N-1:0] sts_pnd,
  irq_ctl_if.master        vec,
`ifdef IRQ_CTL_HOLDOFF_EN
  input  logic [15:0]      cfg_hld,
`endif
  output logic             irq
);

  import irq_ctl_pkg::*;

  irq_ctl_st_t      st, st_nxt;
  logic [IRQ_N-1:0] src_q, pnd, evt, req, clr, hs_oh;
  logic [NW-1:0]    ptr, num_q, num_nxt, gnt_num;
  logic             gnt_vld, vld, hs, hld_ok, irq_q;

  assign evt = irq_src & ~(src_q & cfg_edg);
  assign req = pnd & cfg_msk;

  // offer is withdrawn as soon as the offered bit is cleared or masked
  assign vld = (st == OFFER) && req[num_q];
  assign hs  = vld && vec.vec_rdy;

  always_comb begin
    hs_oh = '0;
    if (hs) begin
      hs_oh[num_q] = 1'b1;
    end
  end

  assign clr = (clr_vld ? clr_msk : '0) | hs_oh;

  irq_ctl_arb #(.N(IRQ_N)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt_vld (gnt_vld),
    .gnt_num (gnt_num)
  );

`ifdef IRQ_CTL_HOLDOFF_EN
  logic [15:0] hld_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      hld_cnt <= '0;
    end else if (hs) begin
      hld_cnt <= cfg_hld;
    end else if (hld_cnt != '0) begin
      hld_cnt <= hld_cnt - 16'd1;
    end
  end

  assign hld_ok = (hld_cnt == '0);
`else
  assign hld_ok = 1'b1;
`endif

  always_comb begin
    st_nxt  = st;
    num_nxt = num_q;
    case (st)
      IDLE: begin
        if (gnt_vld && hld_ok) begin
          st_nxt  = OFFER;
          num_nxt = gnt_num;
        end
      end
      OFFER: begin
        if (hs || !req[num_q]) begin
          st_nxt = IDLE;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      num_q <= '0;
      ptr   <= '0;
      pnd   <= '0;
      src_q <= '0;
      irq_q <= 1'b0;
    end else begin
      st    <= st_nxt;
      num_q <= num_nxt;
      src_q <= irq_src;
      pnd   <= (pnd & ~clr) | evt;
      irq_q <= (|req) && hld_ok;
      if (hs) begin
        ptr <= (num_q == NW'(IRQ_N - 1)) ? '0 : num_q + 1'b1;
      end
    end
  end

  assign sts_pnd     = pnd;
  assign vec.vec_vld = vld;
  assign vec.vec_num = num_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Directed bench for irq_ctl: reset, edge/level sources, round-robin order, masking, set/clear race, reset abort.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
module tb_irq_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] irq_src, cfg_msk, cfg_edg, clr_msk, sts_pnd;
  logic       clr_vld, irq;
`ifdef IRQ_CTL_HOLDOFF_EN
  logic [15:0] cfg_hld;
  int          cyc;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_ctl_if #(.N(6)) vec ();

  irq_ctl #(.IRQ_N(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_src (irq_src),
    .cfg_msk (cfg_msk),
    .cfg_edg (cfg_edg),
    .clr_vld (clr_vld),
    .clr_msk (clr_msk),
    .sts_pnd (sts_pnd),
    .vec     (vec),
`ifdef IRQ_CTL_HOLDOFF_EN
    .cfg_hld (cfg_hld),
`endif
    .irq     (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse the given sources for one cycle, hold vec_rdy high and check the offered
  // numbers in order; exps packs 3-bit numbers, first one in [2:0].
  task automatic rr(input logic [5:0] pulse, input int n, input logic [8:0] exps);
    irq_src = pulse;
    step();
    irq_src     = '0;
    vec.vec_rdy = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      chk($sformatf("rr_vld%0d", k), 32'(vec.vec_vld), 32'd1);
      chk($sformatf("rr_num%0d", k), 32'(vec.vec_num), 32'(exps[3*k +: 3]));
      step();
      chk($sformatf("rr_drop%0d", k), 32'(vec.vec_vld), 32'd0);
    end
    vec.vec_rdy = 1'b0;
    chk("rr_pnd_empty", 32'(sts_pnd), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    irq_src     = '0;
    cfg_msk     = '1;
    cfg_edg     = '1;
    clr_vld     = 1'b0;
    clr_msk     = '0;
    vec.vec_rdy = 1'b0;
`ifdef IRQ_CTL_HOLDOFF_EN
    cfg_hld     = 16'd0;
`endif
    step();
    step();
    rst = 1'b0;
    chk("rst_pnd", 32'(sts_pnd), 32'd0);
    chk("rst_vld", 32'(vec.vec_vld), 32'd0);
    chk("rst_num", 32'(vec.vec_num), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    // single edge pulse on osc[0] (bit 2)
    irq_src = 6'b000100;
    step();
    irq_src = '0;
    chk("e_pnd", 32'(sts_pnd), 32'b000100);
    chk("e_irq_early", 32'(irq), 32'd0);
    chk("e_vld_early", 32'(vec.vec_vld), 32'd0);
    step();
    chk("e_irq", 32'(irq), 32'd1);
    chk("e_vld", 32'(vec.vec_vld), 32'd1);
    chk("e_num", 32'(vec.vec_num), 32'd2);
    step();
    chk("e_hold_vld", 32'(vec.vec_vld), 32'd1);
    chk("e_hold_num", 32'(vec.vec_num), 32'd2);
    vec.vec_rdy = 1'b1;
    step();
    vec.vec_rdy = 1'b0;
    chk("e_hs_pnd", 32'(sts_pnd), 32'd0);
    chk("e_hs_vld", 32'(vec.vec_vld), 32'd0);
    chk("e_hs_irq", 32'(irq), 32'd1);
    step();
    chk("e_irq_drop", 32'(irq), 32'd0);

    // round-robin from a fresh pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    rr(6'b101001, 3, {3'd5, 3'd3, 3'd0});
    rr(6'b100001, 2, {3'd0, 3'd5, 3'd0});
    rr(6'b000001, 1, {3'd0, 3'd0, 3'd0});
    rr(6'b001001, 2, {3'd0, 3'd0, 3'd3});

    // masked source latches but stays silent until enabled
    cfg_msk = 6'b111101;
    irq_src = 6'b000010;
    step();
    irq_src = '0;
    step();
    step();
    chk("m_pnd", 32'(sts_pnd), 32'b000010);
    chk("m_irq", 32'(irq), 32'd0);
    chk("m_vld", 32'(vec.vec_vld), 32'd0);
    cfg_msk = '1;
    step();
    chk("m_vld_on", 32'(vec.vec_vld), 32'd1);
    chk("m_num", 32'(vec.vec_num), 32'd1);
    chk("m_irq_on", 32'(irq), 32'd1);
    vec.vec_rdy = 1'b1;
    step();
    vec.vec_rdy = 1'b0;
    chk("m_pnd_clr", 32'(sts_pnd), 32'd0);
    step();

    // set wins over clear, then clear while offering
    irq_src = 6'b010000;
    clr_vld = 1'b1;
    clr_msk = 6'b010000;
    step();
    irq_src = '0;
    clr_vld = 1'b0;
    clr_msk = '0;
    chk("sc_pnd", 32'(sts_pnd), 32'b010000);
    step();
    chk("sc_vld", 32'(vec.vec_vld), 32'd1);
    chk("sc_num", 32'(vec.vec_num), 32'd4);
    clr_vld = 1'b1;
    clr_msk = 6'b010000;
    step();
    clr_vld = 1'b0;
    clr_msk = '0;
    chk("sc_clr_pnd", 32'(sts_pnd), 32'd0);
    chk("sc_clr_vld", 32'(vec.vec_vld), 32'd0);
    step();
    chk("sc_idle_vld", 32'(vec.vec_vld), 32'd0);
    chk("sc_idle_irq", 32'(irq), 32'd0);

    // level source held high: re-offered after the handshake
    cfg_edg = 6'b111110;
    irq_src = 6'b000001;
    step();
    step();
    chk("lv_vld", 32'(vec.vec_vld), 32'd1);
    chk("lv_num", 32'(vec.vec_num), 32'd0);
`ifdef IRQ_CTL_HOLDOFF_EN
    cfg_hld = 16'd20;
`endif
    vec.vec_rdy = 1'b1;
    step();
    vec.vec_rdy = 1'b0;
    chk("lv_hs_vld", 32'(vec.vec_vld), 32'd0);
    chk("lv_hs_pnd", 32'(sts_pnd), 32'b000001);
`ifdef IRQ_CTL_HOLDOFF_EN
    step();
    cyc = 1;
    chk("lv_hld_irq", 32'(irq), 32'd0);
    while (!vec.vec_vld && cyc < 100) begin
      step();
      cyc++;
    end
    chk("lv_hld_gap", 32'(cyc), 32'd21);
`else
    step();
`endif
    chk("lv_vld2", 32'(vec.vec_vld), 32'd1);
    chk("lv_num2", 32'(vec.vec_num), 32'd0);

    // reset while offering aborts the offer; low source after release is no edge
    rst     = 1'b1;
    irq_src = '0;
    step();
    chk("ro_pnd", 32'(sts_pnd), 32'd0);
    chk("ro_vld", 32'(vec.vec_vld), 32'd0);
    chk("ro_num", 32'(vec.vec_num), 32'd0);
    chk("ro_irq", 32'(irq), 32'd0);
    rst     = 1'b0;
    cfg_edg = '1;
    step();
    step();
    chk("ro_post_pnd", 32'(sts_pnd), 32'd0);
    chk("ro_post_irq", 32'(irq), 32'd0);
    chk("ro_post_vld", 32'(vec.vec_vld), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
